// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a shared-datapath multicycle RV32I core.
// Walks lw/sw/R/I/beq/jal through fetch, decode, execute, memory and
// writeback; any other opcode parks the core in HALT until reset.
// Ports: clk, rst_n (async, active low), op (IR[6:0]), zero (ALU flag),
//   mem_ready (memory done, only with MULTICYCLE_MEM_WAIT_EN);
//   pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
//   alu_src_a, alu_src_b, alu_op, imm_src, halted, state_o (debug).
// Option: define MULTICYCLE_MEM_WAIT_EN to stall FETCH, MEMREAD and
//   MEMWRITE until mem_ready=1; otherwise each lasts one cycle.
module multicycle_ctrl #(
   parameter int OP_W = 7,
   parameter int ST_W = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OP_W-1:0] op,
   input  logic            zero,
   input  logic            mem_ready,
   output logic            pc_write,
   output logic            adr_src,
   output logic            mem_write,
   output logic            ir_write,
   output logic            reg_write,
   output logic [1:0]      result_src,
   output logic [1:0]      alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic [1:0]      alu_op,
   output logic [1:0]      imm_src,
   output logic            halted,
   output logic [ST_W-1:0] state_o
);

   typedef enum logic [ST_W-1:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXEC_R   = 4'd6,
      S_EXEC_I   = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_HALT     = 4'd11
   } state_e;

   localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
   localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
   localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
   localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
   localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
   localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

   state_e state_q, state_d;
   logic   mem_rdy;
   logic   pc_update;
   logic   branch;
   logic   ir_write_raw;

`ifdef MULTICYCLE_MEM_WAIT_EN
   assign mem_rdy = mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
   assign mem_rdy = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_FETCH: if (mem_rdy) state_d = S_DECODE;
         S_DECODE: begin
            if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
            else if (op == OP_R)            state_d = S_EXEC_R;
            else if (op == OP_I)            state_d = S_EXEC_I;
            else if (op == OP_BEQ)          state_d = S_BEQ;
            else if (op == OP_JAL)          state_d = S_JAL;
            else                            state_d = S_HALT;
         end
         S_MEMADR:
            state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_rdy) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (mem_rdy) state_d = S_FETCH;
         S_EXEC_R:   state_d = S_ALUWB;
         S_EXEC_I:   state_d = S_ALUWB;
         S_JAL:      state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_HALT;
      endcase
   end

   always_comb begin
      adr_src      = 1'b0;
      mem_write    = 1'b0;
      ir_write_raw = 1'b0;
      reg_write    = 1'b0;
      result_src   = 2'b00;
      alu_src_a    = 2'b00;
      alu_src_b    = 2'b00;
      alu_op       = 2'b00;
      pc_update    = 1'b0;
      branch       = 1'b0;
      halted       = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            ir_write_raw = mem_rdy;
            pc_update    = mem_rdy;
            alu_src_b    = 2'b10;
            result_src   = 2'b10;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         S_MEMREAD: adr_src = 1'b1;
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
         end
         S_EXEC_R: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
         end
         S_EXEC_I: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
         end
         S_ALUWB: reg_write = 1'b1;
         S_BEQ: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            branch    = 1'b1;
         end
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_update = 1'b1;
         end
         S_HALT: halted = 1'b1;
         default: halted = 1'b1;
      endcase
   end

   // rst_n gates the two enables so nothing loads while reset is held
   assign ir_write = rst_n & ir_write_raw;
   assign pc_write = rst_n & (pc_update | (branch & zero));

   always_comb begin
      imm_src = 2'b00;
      if (op == OP_SW)       imm_src = 2'b01;
      else if (op == OP_BEQ) imm_src = 2'b10;
      else if (op == OP_JAL) imm_src = 2'b11;
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed checks of the multicycle control FSM.
// Linear stimulus with immediate assertions at every comparison point.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
   logic       halted;
   logic [3:0] state_o;

   int total  = 0;
   int passed = 0;

`ifdef MULTICYCLE_MEM_WAIT_EN
   localparam int SW_CYC = 4;
`else
   localparam int SW_CYC = 1;
`endif

   multicycle_ctrl #(.OP_W(7), .ST_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
      .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
      .result_src(result_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
      .halted(halted), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      int rw;
      logic [3:0] seq_r [4];
      logic [3:0] seq_i [4];
      seq_r = '{4'd0, 4'd1, 4'd6, 4'd8};
      seq_i = '{4'd0, 4'd1, 4'd7, 4'd8};

      rst_n = 1'b0; op = 7'b0000011; zero = 1'b0; mem_ready = 1'b1;
      #12;
      chk("rst_state", state_o, 0);
      chk("rst_halted", halted, 0);
      chk("rst_ir_write", ir_write, 0);
      chk("rst_pc_write", pc_write, 0);
      chk("rst_alu_src_b", alu_src_b, 2);
      chk("rst_result_src", result_src, 2);
      rst_n = 1'b1;
      #1;
      chk("fetch_ir_write", ir_write, 1);
      chk("fetch_pc_write", pc_write, 1);
      chk("fetch_adr_src", adr_src, 0);

      // lw: 0,1,2,3,4,0
      tick();
      chk("lw_decode", state_o, 1);
      chk("lw_dec_a", alu_src_a, 1);
      chk("lw_dec_b", alu_src_b, 1);
      chk("lw_dec_pcw", pc_write, 0);
      chk("lw_imm", imm_src, 0);
      tick();
      chk("lw_memadr", state_o, 2);
      chk("lw_adr_a", alu_src_a, 2);
      chk("lw_adr_rw", reg_write, 0);
      tick();
      chk("lw_memread", state_o, 3);
      chk("lw_rd_adr", adr_src, 1);
      chk("lw_rd_rw", reg_write, 0);
      tick();
      chk("lw_memwb", state_o, 4);
      chk("lw_wb_rw", reg_write, 1);
      chk("lw_wb_rsrc", result_src, 1);
      chk("lw_wb_pcw", pc_write, 0);
      tick();
      chk("lw_done", state_o, 0);

      // sw with mem_ready low for 3 cycles in MEMWRITE
      op = 7'b0100011;
      #1;
      chk("sw_imm", imm_src, 1);
      tick();
      chk("sw_decode", state_o, 1);
      tick();
      chk("sw_memadr", state_o, 2);
      tick();
      n = 0;
      while (state_o == 4'd5 && n < 10) begin
         mem_ready = (n >= 3);
         #1;
         chk("sw_mem_write", mem_write, 1);
         n++;
         tick();
      end
      mem_ready = 1'b1;
      chk("sw_cycles", n, SW_CYC);
      chk("sw_done", state_o, 0);

      // reset in the middle of a store
      tick(); tick(); tick();
      chk("rst_mid_state", state_o, 5);
      chk("rst_mid_mw_pre", mem_write, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_mw", mem_write, 0);
      chk("rst_mid_state0", state_o, 0);
      chk("rst_mid_halted", halted, 0);
      chk("rst_mid_irw", ir_write, 0);
      chk("rst_mid_pcw", pc_write, 0);
      #2;
      rst_n = 1'b1;
      tick();
      chk("rst_rel_decode", state_o, 1);
      tick(); tick(); tick();
      chk("rst_sw_done", state_o, 0);

      // beq
      op = 7'b1100011;
      tick();
      tick();
      chk("beq_state", state_o, 9);
      zero = 1'b1;
      #1;
      chk("beq_z1_pcw", pc_write, 1);
      chk("beq_z1_aluop", alu_op, 1);
      chk("beq_z1_imm", imm_src, 2);
      zero = 1'b0;
      #1;
      chk("beq_z0_pcw", pc_write, 0);
      chk("beq_z0_aluop", alu_op, 1);
      chk("beq_z0_imm", imm_src, 2);
      tick();
      chk("beq_done", state_o, 0);

      // R-type then I-type back-to-back
      op = 7'b0110011;
      rw = 0;
      for (int i = 0; i < 4; i++) begin
         chk("r_seq", state_o, seq_r[i]);
         if (state_o == 4'd6) chk("r_aluop", alu_op, 2);
         rw += int'(reg_write);
         tick();
      end
      chk("r_rw_pulses", rw, 1);
      op = 7'b0010011;
      #1;
      rw = 0;
      for (int i = 0; i < 4; i++) begin
         chk("i_seq", state_o, seq_i[i]);
         if (state_o == 4'd7) chk("i_aluop", alu_op, 2);
         rw += int'(reg_write);
         tick();
      end
      chk("i_rw_pulses", rw, 1);
      chk("i_done", state_o, 0);

      // jal
      op = 7'b1101111;
      #1;
      chk("jal_imm", imm_src, 3);
      tick(); tick();
      chk("jal_state", state_o, 10);
      chk("jal_pcw", pc_write, 1);
      chk("jal_a", alu_src_a, 1);
      chk("jal_b", alu_src_b, 2);
      tick();
      chk("jal_aluwb", state_o, 8);
      chk("jal_rw", reg_write, 1);
      tick();
      chk("jal_done", state_o, 0);

      // illegal opcode
      op = 7'b1111111;
      tick();
      chk("ill_decode", state_o, 1);
      chk("ill_not_halted", halted, 0);
      for (int i = 0; i < 22; i++) begin
         tick();
         chk("ill_state", state_o, 11);
         chk("ill_halted", halted, 1);
         chk("ill_enables",
             {pc_write, ir_write, reg_write, mem_write}, 0);
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("ill_rst_halted", halted, 0);
      chk("ill_rst_state", state_o, 0);
      #2;
      rst_n = 1'b1;
      tick();
      chk("ill_rst_decode", state_o, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
